// File: rtl/vxe_reg_pkg.sv
// rtl/vxe_reg_pkg.sv - shared register-file constants and word type
package vxe_reg_pkg;

    localparam int unsigned VXE_REG_DEFAULT_WIDTH = 32;

    typedef logic [VXE_REG_DEFAULT_WIDTH-1:0] vxe_reg_word_t;

endpackage

// File: rtl/vxe_reg_arst.sv
// rtl/vxe_reg_arst.sv - write-enabled register with async reset to RST_VALUE
// Optional synchronous clear port enabled by VXE_REG_ARST_CLR_EN.
module vxe_reg_arst
    import vxe_reg_pkg::*;
#(
    parameter int unsigned                DATA_WIDTH = VXE_REG_DEFAULT_WIDTH,
    parameter logic [DATA_WIDTH-1:0]      RST_VALUE  = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
`ifdef VXE_REG_ARST_CLR_EN
    input  logic                  clr,
`endif
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] data_d;
    logic [DATA_WIDTH-1:0] data_q;

    // clr outranks wr_en; rst is handled by the flop's async branch.
    always_comb begin
        data_d = data_q;
`ifdef VXE_REG_ARST_CLR_EN
        if (clr) begin
            data_d = RST_VALUE;
        end else if (wr_en) begin
            data_d = data_in;
        end
`else
        if (wr_en) begin
            data_d = data_in;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= RST_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_out = data_q;

endmodule

// File: tb/tb_vxe_reg_arst.sv
// tb/tb_vxe_reg_arst.sv - randomized self-checking bench for vxe_reg_arst
module tb_vxe_reg_arst;
    import vxe_reg_pkg::*;

    localparam vxe_reg_word_t RV = 32'hdead_beef;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic          clr;
    vxe_reg_word_t data_in;
    vxe_reg_word_t data_out;
    vxe_reg_word_t exp_val;
    int            n_checks = 0;
    int            n_errors = 0;

    always #5 clk = ~clk;

    vxe_reg_arst #(
        .DATA_WIDTH (32),
        .RST_VALUE  (RV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
`ifdef VXE_REG_ARST_CLR_EN
        .clr      (clr),
`endif
        .data_in  (data_in),
        .data_out (data_out)
    );

    task automatic check(input string tag, input vxe_reg_word_t obs, input vxe_reg_word_t expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference behaviour at a rising edge: rst > clr > wr_en > hold.
    task automatic tick(input string tag);
        @(posedge clk);
        if (rst) begin
            exp_val = RV;
        end
`ifdef VXE_REG_ARST_CLR_EN
        else if (clr) begin
            exp_val = RV;
        end
`endif
        else if (wr_en) begin
            exp_val = data_in;
        end
        #1;
        check(tag, data_out, exp_val);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b0;
        wr_en   = 1'b0;
        clr     = 1'b0;
        data_in = '0;
        exp_val = '0;

        #2 rst = 1'b1;
        #1 check("rst_async", data_out, RV);
        exp_val = RV;
        repeat (4) begin
            wr_en   = 1'b1;
            data_in = $urandom;
            tick("rst_hold");
        end
        rst   = 1'b0;
        wr_en = 1'b0;
        repeat (2) tick("rel_hold");

        wr_en   = 1'b1;
        data_in = 32'hfefe_0000;
        tick("wr1");
        wr_en = 1'b0;
        repeat (4) begin
            data_in = $urandom;
            tick("idle1");
        end

        wr_en   = 1'b1;
        data_in = 32'hbebe_0000;
        tick("wr2");
        wr_en = 1'b0;
        tick("hold2");

        #2;
        rst     = 1'b1;
        wr_en   = 1'b1;
        data_in = 32'h5555_aaaa;
        #1 check("async_rst", data_out, RV);
        exp_val = RV;
        tick("rst_wins");
        rst   = 1'b0;
        wr_en = 1'b0;
        tick("post_rst");

        for (int i = 1; i <= 3; i++) begin
            wr_en   = 1'b1;
            data_in = i;
            tick("b2b");
        end
        wr_en = 1'b0;

`ifdef VXE_REG_ARST_CLR_EN
        clr     = 1'b1;
        wr_en   = 1'b1;
        data_in = 32'h1234_5678;
        tick("clr_prio");
        clr     = 1'b0;
        data_in = 32'h0000_00a5;
        tick("clr_after_wr");
        clr   = 1'b1;
        wr_en = 1'b0;
        tick("clr_only");
        clr = 1'b0;
`endif

        for (int i = 0; i < 300; i++) begin
            wr_en   = 1'($urandom_range(0, 1));
            data_in = $urandom;
`ifdef VXE_REG_ARST_CLR_EN
            clr = ($urandom_range(0, 7) == 0);
`endif
            if ($urandom_range(0, 15) == 0) begin
                #2 rst = 1'b1;
                #1 check("rnd_async_rst", data_out, RV);
                exp_val = RV;
                #1 rst = 1'b0;
            end
            tick("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
